// File: rtl/fpadd_pkg.sv
// Shared constants and types for the pipelined floating-point adder.
package fpadd_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam int DEF_W     = 1 + DEF_EXP_W + DEF_MAN_W;

  localparam int BIAS = (1 << (DEF_EXP_W - 1)) - 1;
  localparam logic [DEF_EXP_W-1:0] EXP_MAX = '1;

  // Canonical quiet NaN: positive, all-ones exponent, top mantissa bit set.
  localparam logic [DEF_W-1:0] QNAN = {1'b0, {DEF_EXP_W{1'b1}}, 1'b1, {(DEF_MAN_W-1){1'b0}}};

  // Bit positions inside the 4-bit flags word.
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_NX  = 0;

  // Unpacked operand at the default widths (sig includes the hidden bit).
  typedef struct packed {
    logic                 sign;
    logic [DEF_EXP_W-1:0] exp;
    logic [DEF_MAN_W:0]   sig;
    logic                 is_zero;
    logic                 is_inf;
    logic                 is_nan;
  } fp_unpacked_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module fp_lzc
  import fpadd_pkg::*;
#(
  parameter  int WIDTH = 27,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CW-1:0]    cnt_o
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    cnt_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in_i[i]) cnt_o = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpadd_pipe.sv
// Four-stage pipelined FP add/sub with global-stall valid/ready flow control.
// The operand pair presented in cycle k is loaded at the following edge and
// its rounded result is visible after edge k+4.
module fpadd_pipe
  import fpadd_pkg::*;
#(
  parameter  int EXP_W = DEF_EXP_W,
  parameter  int MAN_W = DEF_MAN_W,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int SW = MAN_W + 1;          // significand with hidden bit
  localparam int F  = MAN_W + 4;          // {ovf, 1.man, G, R}
  localparam int X  = F + 1;              // F with sticky appended as LSB
  localparam int LW = $clog2(F + 1);
  localparam int EW = EXP_W + 2;          // exponent working width, MSB = sign
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] QNAN_W = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Same layout as fp_unpacked_t, sized by this instance's parameters.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    sig;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } unp_t;

  typedef struct packed {
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    sig_b;
    logic [SW-1:0]    sig_s;
    logic [EXP_W-1:0] d;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [X-1:0]     big_f;
    logic [X-1:0]     sml_f;
  } s2_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [X-1:0]     sum;
    logic [LW-1:0]    lzc;
  } s3_t;

  // Special-case bypass travelling alongside the arithmetic.
  typedef struct packed {
    logic         spc;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } tag_t;

  function automatic unp_t unpack(input logic [W-1:0] v, input logic flip);
    unp_t u;
    u.sign    = v[W-1] ^ flip;
    u.exp     = v[W-2 -: EXP_W];
    u.is_zero = (u.exp == '0);
    u.is_inf  = (u.exp == EXP_ONES) && (v[MAN_W-1:0] == '0);
    u.is_nan  = (u.exp == EXP_ONES) && (v[MAN_W-1:0] != '0);
    u.sig     = {~u.is_zero, v[MAN_W-1:0]};
    return u;
  endfunction

  logic            advance;
  logic            v1_q, v2_q, v3_q, out_valid_q;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  s3_t             s3_d, s3_q;
  tag_t            t1_d, t1_q, t2_q, t3_q;
  logic [W-1:0]    result_d, result_q;
  logic [3:0]      flags_d, flags_q;

  unp_t            ua, ub;
  logic            a_ge_b;
  logic [2*F-1:0]  sh;
  logic [X-1:0]    sum3;
  logic [LW-1:0]   lzc3;
  logic [F-1:0]    nrm;
  logic [EW-1:0]   e_n, e_r;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] man_out;
  logic            g, r, st, inc, rc;

  assign advance   = !out_valid_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // S1: unpack, resolve specials, order by magnitude, exponent difference.
  always_comb begin
    ua     = unpack(op_a, 1'b0);
    ub     = unpack(op_b, op_sub);
    a_ge_b = op_a[W-2:0] >= op_b[W-2:0];
    s1_d.sign    = a_ge_b ? ua.sign : ub.sign;
    s1_d.eff_sub = ua.sign ^ ub.sign;
    s1_d.exp     = a_ge_b ? ua.exp : ub.exp;
    s1_d.sig_b   = a_ge_b ? ua.sig : ub.sig;
    s1_d.sig_s   = a_ge_b ? ub.sig : ua.sig;
    s1_d.d       = a_ge_b ? (ua.exp - ub.exp) : (ub.exp - ua.exp);
    t1_d.spc = 1'b1;
    t1_d.res = '0;
    t1_d.flg = '0;
    if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && (ua.sign != ub.sign))) begin
      t1_d.res          = QNAN_W;
      t1_d.flg[FLG_INV] = 1'b1;
    end else if (ua.is_inf) begin
      t1_d.res = {ua.sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (ub.is_inf) begin
      t1_d.res = {ub.sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (ua.is_zero && ub.is_zero) begin
      t1_d.res = {ua.sign & ub.sign, {(W-1){1'b0}}};
    end else if (ua.is_zero) begin
      t1_d.res = {ub.sign, op_b[W-2:0]};
    end else if (ub.is_zero) begin
      t1_d.res = op_a;
    end else begin
      t1_d.spc = 1'b0;
    end
  end

  // S2: align the small significand; shifted-out bits collapse into sticky.
  always_comb begin
    s2_d.sign    = s1_q.sign;
    s2_d.eff_sub = s1_q.eff_sub;
    s2_d.exp     = s1_q.exp;
    s2_d.big_f   = {1'b0, s1_q.sig_b, 3'b000};
    sh           = '0;
    if (s1_q.d >= EXP_W'(MAN_W + 3)) begin
      s2_d.sml_f = {{(X-1){1'b0}}, (s1_q.sig_s != '0)};
    end else begin
      sh         = {1'b0, s1_q.sig_s, 2'b00, {F{1'b0}}} >> s1_q.d;
      s2_d.sml_f = {sh[2*F-1:F], |sh[F-1:0]};
    end
  end

  // S3: magnitude add/subtract; sticky takes part so borrows round correctly.
  assign sum3 = s2_q.eff_sub ? (s2_q.big_f - s2_q.sml_f) : (s2_q.big_f + s2_q.sml_f);

  fp_lzc #(.WIDTH(F)) u_lzc (
    .in_i  (sum3[X-2:0]),
    .cnt_o (lzc3)
  );

  // S3 register inputs.
  always_comb begin
    s3_d.sign = s2_q.sign;
    s3_d.exp  = s2_q.exp;
    s3_d.sum  = sum3;
    s3_d.lzc  = lzc3;
  end

  // S4: normalise, round to nearest even, detect range errors, pack.
  always_comb begin
    if (s3_q.sum[X-1]) begin
      nrm = {s3_q.sum[X-1:2], s3_q.sum[1] | s3_q.sum[0]};
      e_n = EW'(s3_q.exp) + EW'(1);
    end else begin
      nrm = s3_q.sum[X-2:0] << s3_q.lzc;
      e_n = EW'(s3_q.exp) - EW'(s3_q.lzc);
    end
    g       = nrm[2];
    r       = nrm[1];
    st      = nrm[0];
    inc     = g & (r | st | nrm[3]);
    mant_r  = {1'b0, nrm[F-1:3]} + (MAN_W+2)'(inc);
    rc      = mant_r[MAN_W+1];
    e_r     = e_n + EW'(rc);
    man_out = rc ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    result_d = '0;
    flags_d  = '0;
    if (t3_q.spc) begin
      result_d = t3_q.res;
      flags_d  = t3_q.flg;
    end else if (s3_q.sum == '0) begin
      result_d = '0;
    end else if (e_n[EW-1] || (e_n == '0)) begin
      result_d         = {s3_q.sign, {(W-1){1'b0}}};
      flags_d[FLG_UNF] = 1'b1;
      flags_d[FLG_NX]  = 1'b1;
    end else if (e_r >= EW'(EXP_ONES)) begin
      result_d         = {s3_q.sign, EXP_ONES, {MAN_W{1'b0}}};
      flags_d[FLG_OVF] = 1'b1;
      flags_d[FLG_NX]  = 1'b1;
    end else begin
      result_d        = {s3_q.sign, e_r[EXP_W-1:0], man_out};
      flags_d[FLG_NX] = g | r | st;
    end
  end

  // Stage registers: everything moves together only when the pipe advances.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      t1_q        <= '0;
      t2_q        <= '0;
      t3_q        <= '0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (advance) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      out_valid_q <= v3_q;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      t1_q        <= t1_d;
      t2_q        <= t1_q;
      t3_q        <= t2_q;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_fpadd_pipe.sv
// Directed bench for fpadd_pipe at FP32 widths.
module tb_fpadd_pipe;
  import fpadd_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        op_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;

  int total = 0;
  int bad   = 0;

  fpadd_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic [3:0]  flg;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [31:0] res, input logic [3:0] flg, input string name);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.res = res; v.flg = flg; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // One isolated operation: exactly 4 edges of latency, one-cycle out_valid pulse.
  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    in_valid = 1'b1; op_a = v.a; op_b = v.b; op_sub = v.sub;
    for (int c = 1; c < 4; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({v.name, "/early"}, {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    check({v.name, "/valid"}, {31'd0, out_valid}, 32'd1);
    check({v.name, "/res"}, result, v.res);
    check({v.name, "/flags"}, {28'd0, flags}, {28'd0, v.flg});
    @(posedge clk); #1;
    check({v.name, "/pulse"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int k, j, cyc;
    logic exp_rdy;

    add_vec(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, "one_plus_one");
    add_vec(32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000, "cancel_ulp");
    add_vec(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0000, "cancel_zero");
    add_vec(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, "tie_even");
    add_vec(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, "tie_odd_up");
    add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, "overflow");
    add_vec(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, "inf_m_inf");
    add_vec(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, "nan_in");
    add_vec(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, "three_m_one");
    add_vec(32'h3F800000, 32'h40400000, 1'b0, 32'h40800000, 4'b0000, "carry_out");
    add_vec(32'h3F7FFFFF, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000, "exact_carry");
    add_vec(32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 4'b0001, "round_carry");
    add_vec(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'b0000, "sub_exact");
    add_vec(32'h3F800000, 32'h33000001, 1'b1, 32'h3F7FFFFF, 4'b0001, "sub_sticky");
    add_vec(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001, "far_apart");
    add_vec(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'b0011, "underflow");
    add_vec(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, "negz_negz");
    add_vec(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000, "mixed_zero");
    add_vec(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000, "negz_m_z");
    add_vec(32'h00000000, 32'hC0490FDB, 1'b0, 32'hC0490FDB, 4'b0000, "zero_a");
    add_vec(32'h40490FDB, 32'h00000000, 1'b1, 32'h40490FDB, 4'b0000, "zero_b");
    add_vec(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, "minus_inf");
    add_vec(32'hBF800000, 32'hBFC00000, 1'b0, 32'hC0200000, 4'b0000, "neg_add");
    add_vec(32'h3F800000, 32'hC0000000, 1'b0, 32'hBF800000, 4'b0000, "b_bigger");

    #23;
    check("rst/out_valid", {31'd0, out_valid}, 32'd0);
    check("rst/in_ready", {31'd0, in_ready}, 32'd1);
    check("rst/result", result, 32'd0);
    check("rst/flags", {28'd0, flags}, 32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: 8 back-to-back ops of 2^k + 2^k, consumer stalls cycles 5-7.
    k = 0; j = 0; cyc = 0;
    @(posedge clk);
    while (j < 8 && cyc < 40) begin
      #1;
      out_ready = !(cyc >= 5 && cyc <= 7);
      in_valid  = (k < 8);
      op_a      = 32'h3F800000 + (k << 23);
      op_b      = 32'h3F800000 + (k << 23);
      op_sub    = 1'b0;
      #1;
      exp_rdy = !(cyc >= 5 && cyc <= 7);
      check($sformatf("bp/in_ready c%0d", cyc), {31'd0, in_ready}, {31'd0, exp_rdy});
      if (out_valid) begin
        check($sformatf("bp/res%0d c%0d", j, cyc), result, 32'h40000000 + (j << 23));
        if (out_ready) j++;
      end
      if (in_valid && in_ready) k++;
      cyc++;
      @(posedge clk);
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp/delivered", j, 8);
    check("bp/accepted", k, 8);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("bp/no_dup", {31'd0, out_valid}, 32'd0);
    end

    // Reset while operations are in flight and the output is valid.
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      op_a = 32'h3F800000; op_b = 32'h3F800000 + (c << 23); op_sub = 1'b0;
    end
    @(posedge clk); #1;
    check("rstmid/pre_valid", {31'd0, out_valid}, 32'd1);
    #1;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rstmid/out_valid", {31'd0, out_valid}, 32'd0);
    check("rstmid/result", result, 32'd0);
    check("rstmid/flags", {28'd0, flags}, 32'd0);
    check("rstmid/in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #3;
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check($sformatf("rstmid/quiet c%0d", c), {31'd0, out_valid}, 32'd0);
    end
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpadd_pipe.md
# fpadd_pipe

Parametrised, 4-stage pipelined floating-point adder/subtractor with valid/ready flow control, full post-normalisation and round-to-nearest-even. It is the next-generation add unit of the FPU datapath and replaces the single-cycle FP32 adder. It accepts one operation per cycle and covers zero, infinity, NaN, overflow and underflow. Subnormals are flushed to zero.

## Interface
- `EXP_W`, 8: exponent field width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, 23: stored mantissa width (hidden bit excluded); word width W = 1+EXP_W+MAN_W.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  adder accepts operands this cycle.
- `op_a`  in  W  operand A, IEEE-style {sign, exp, man}.
- `op_b`  in  W  operand B.
- `op_sub`  in  1  1: compute A-B (B sign inverted in stage 1); 0: A+B.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  W  rounded sum.
- `flags`  out  4  {invalid, overflow, underflow, inexact}, aligned with `result`.

## Operation
- S1, unpack/swap:
  - Exp==0 is treated as signed zero.
  - Exp all-ones with man==0 is ±inf; with man!=0 it is NaN.
  - Prepend the hidden bit. Order operands by magnitude ({exp,man} unsigned compare) so big ≥ small.
  - Compute d = exp_big − exp_small.
- S2, align:
  - Shift the small significand right by d into a (MAN_W+4)-bit field {ovf, 1.man, G, R}, plus a sticky bit = OR of all bits shifted out.
  - d ≥ MAN_W+3 yields sig = 0, sticky = (small != 0).
- S3, add/sub and LZC:
  - Same effective sign: add. Otherwise subtract small from big; the result is never negative.
  - Leading-zero count via sub-module `fp_lzc`.
- S4, normalise/round/pack:
  - Carry out: shift right 1 and exp+1, folding the LSB into sticky.
  - Otherwise shift left by lzc and exp−lzc.
  - RNE: increment when G & (R | S | LSB). A rounding carry renormalises and increments exp.
- Result sign: sign of the larger magnitude. An exact zero from cancellation is +0. (+0)+(+0)=+0, (−0)+(−0)=−0, mixed zeros give +0.
- Specials, which bypass the arithmetic:
  - Any NaN, or inf−inf, gives canonical quiet NaN {0, all-ones, 1,0…0} and sets `invalid`.
  - Otherwise inf gives inf with the inf operand's sign.
  - A zero operand returns the other operand unchanged; inexact = 0.
- Overflow: exp ≥ all-ones after rounding gives ±inf; sets `overflow` and `inexact`.
- Underflow: normalised exp ≤ 0 gives ±0; sets `underflow` and `inexact`.
- `inexact` = G|R|S non-zero, or overflow or underflow.

## Timing
- Latency 4 cycles: operands accepted at edge k appear on `result` after edge k+4 when there is no stall. Throughput is 1 per cycle.
- Global stall: `advance = !out_valid | out_ready`; `in_ready = advance`.
  - All stage registers, including per-stage valid bits, load only when `advance` is high.
  - Bubbles are not squeezed out.
- A transfer occurs when valid and ready are both high in the same cycle. While `out_valid` is high and `out_ready` is low, `result` and `flags` hold stable.
- `in_valid` low while advancing inserts a bubble (stage valid = 0). Data in bubble stages is don't-care but must not toggle `out_valid`.
- Reset (asynchronous, any time, including mid-operation):
  - All stage valids = 0, `out_valid` = 0, `result` = 0, `flags` = 0.
  - In-flight operations are discarded. `in_ready` = 1 after reset.
- Simultaneous output pop and input push in one cycle is legal and loses no data.

## Structure
- Package `fpadd_pkg` holds:
  - Default EXP_W/MAN_W.
  - BIAS and EXP_MAX constants.
  - The canonical-NaN constant.
  - The flag bit indices (INV=3, OVF=2, UNF=1, NX=0).
  - A packed-struct typedef for the unpacked operand {sign, exp, sig, is_zero, is_inf, is_nan}.
- Sub-module `fp_lzc`: parametrised-width leading-zero counter. Combinational, output width $clog2(width+1).
- The top module holds the four stage-register banks, the handshake, and the special-case bypass, which is carried down the pipe as a tag.

## Test plan
- Basic add: 0x3F800000 + 0x3F800000, op_sub=0. After 4 cycles: result 0x40000000, flags 0.
- Cancellation: 0x3F800001 − 0x3F800000 (op_sub=1) gives 0x34000000. 0x3F800000 + 0xBF800000 gives 0x00000000 (+0), flags 0.
- Rounding:
  - 0x3F800000 + 0x33800000 (tie) gives 0x3F800000, inexact=1.
  - 0x3F800001 + 0x33800000 gives 0x3F800002, inexact=1.
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF gives 0x7F800000, flags 0b0101.
  - 0x7F800000 + 0xFF800000 gives 0x7FC00000, invalid=1.
  - NaN input gives 0x7FC00000.
- Backpressure: 8 back-to-back operations with `out_ready` low for cycles 5–7. Required: `in_ready` low during the stall, all 8 results delivered in order with no loss or duplication, `result` stable while stalled.
- Reset: assert `reset_n`=0 with 3 operations in flight. Required: `out_valid` drops immediately, nothing emerges after release, and the first new operation returns correctly 4 cycles after acceptance.
